// File: rtl/pipeline_controller.sv
// Pipeline sequencing for the 5-stage core.
// Owns the data-memory wait FSM, stall/flush controls and perf counters.
module pipeline_controller #(
  parameter int PERF_CNT_WIDTH = 32,
  parameter int DMEM_TIMEOUT   = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      stall_id_i,
  input  logic                      stall_ex_i,
  input  logic                      if_valid_i,
  input  logic                      jump_i,
  input  logic                      branch_taken_i,
  input  logic                      dmem_req_i,
  input  logic                      dmem_gnt_i,
  input  logic                      dmem_rvalid_i,
  output logic                      pc_en_o,
  output logic                      if_id_en_o,
  output logic                      id_ex_en_o,
  output logic                      ex_mem_en_o,
  output logic                      mem_wb_en_o,
  output logic                      if_id_flush_o,
  output logic                      id_ex_flush_o,
  output logic                      ex_mem_flush_o,
  output logic                      mem_wb_flush_o,
  output logic                      dmem_busy_o,
  output logic                      dmem_err_o,
  output logic [PERF_CNT_WIDTH-1:0] stall_cnt_o,
  output logic [PERF_CNT_WIDTH-1:0] flush_cnt_o
);

  localparam int TW = (DMEM_TIMEOUT < 2) ? 1
                    : $clog2(DMEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(DMEM_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } mem_state_e;

  mem_state_e        state_q;
  logic [TW-1:0]     wait_q;
  logic              timeout;
  logic              busy;
  logic              redirect;

  assign timeout = (state_q != IDLE) && (wait_q == TMO);

  // MEM stage is waiting; a timeout cycle counts as completion
  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      IDLE:        busy = dmem_req_i;
      WAIT_GNT:    busy = !timeout;
      WAIT_RVALID: busy = !timeout && !dmem_rvalid_i;
      default:     busy = 1'b0;
    endcase
  end

  assign dmem_busy_o = busy && !rst_i;

  // Stall/flush priority: a stalled stage holds earlier regs, bubbles next
  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    id_ex_en_o     = 1'b1;
    ex_mem_en_o    = 1'b1;
    mem_wb_en_o    = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    redirect       = 1'b0;
    priority case (1'b1)
      rst_i: begin
        pc_en_o        = 1'b0;
        if_id_en_o     = 1'b0;
        id_ex_en_o     = 1'b0;
        ex_mem_en_o    = 1'b0;
        mem_wb_en_o    = 1'b0;
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
        ex_mem_flush_o = 1'b1;
        mem_wb_flush_o = 1'b1;
      end
      busy: begin
        pc_en_o        = 1'b0;
        if_id_en_o     = 1'b0;
        id_ex_en_o     = 1'b0;
        ex_mem_en_o    = 1'b0;
        mem_wb_flush_o = 1'b1;
      end
      stall_ex_i: begin
        pc_en_o        = 1'b0;
        if_id_en_o     = 1'b0;
        id_ex_en_o     = 1'b0;
        ex_mem_flush_o = 1'b1;
      end
      stall_id_i: begin
        pc_en_o       = 1'b0;
        if_id_en_o    = 1'b0;
        id_ex_flush_o = 1'b1;
      end
      branch_taken_i: begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
        redirect      = 1'b1;
      end
      jump_i: begin
        if_id_flush_o = 1'b1;
        redirect      = 1'b1;
      end
      !if_valid_i: begin
        pc_en_o       = 1'b0;
        if_id_flush_o = 1'b1;
      end
      default: begin
        pc_en_o = 1'b1;
      end
    endcase
  end

  // Data-memory handshake FSM with wait-cycle timeout and sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      dmem_err_o <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          wait_q <= '0;
          if (dmem_req_i) begin
            state_q <= dmem_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (timeout) begin
            state_q    <= IDLE;
            dmem_err_o <= 1'b1;
          end else if (dmem_gnt_i) begin
            state_q <= WAIT_RVALID;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        WAIT_RVALID: begin
          if (timeout) begin
            state_q    <= IDLE;
            dmem_err_o <= 1'b1;
          end else if (dmem_rvalid_i) begin
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          wait_q  <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_en_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (redirect && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomized bench for pipeline_controller against a
// stage-level reference model.
module tb_pipeline_controller;

  localparam int W   = 6;
  localparam int TMO = 4;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic stall_id, stall_ex, if_valid, jump, branch;
  logic req, gnt, rvalid;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl;
  logic busy, err;
  logic [W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_active;
  bit m_granted;
  int m_wait;
  bit m_err;
  int m_stall;
  int m_flush;

  always #5 clk = ~clk;

  pipeline_controller #(
    .PERF_CNT_WIDTH(W),
    .DMEM_TIMEOUT  (TMO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_id_i    (stall_id),
    .stall_ex_i    (stall_ex),
    .if_valid_i    (if_valid),
    .jump_i        (jump),
    .branch_taken_i(branch),
    .dmem_req_i    (req),
    .dmem_gnt_i    (gnt),
    .dmem_rvalid_i (rvalid),
    .pc_en_o       (pc_en),
    .if_id_en_o    (if_id_en),
    .id_ex_en_o    (id_ex_en),
    .ex_mem_en_o   (ex_mem_en),
    .mem_wb_en_o   (mem_wb_en),
    .if_id_flush_o (if_id_fl),
    .id_ex_flush_o (id_ex_fl),
    .ex_mem_flush_o(ex_mem_fl),
    .mem_wb_flush_o(mem_wb_fl),
    .dmem_busy_o   (busy),
    .dmem_err_o    (err),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  function automatic logic [9:0] ctrl_vec();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, busy};
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_active  = 0;
    m_granted = 0;
    m_wait    = 0;
    m_err     = 0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  // v = {stall_id, stall_ex, if_valid, jump, branch, req, gnt, rvalid}
  task automatic step(input logic [7:0] v);
    bit       tmo, e_busy, hold, redir;
    int       k;
    logic [4:0] e_en, e_fl;
    @(negedge clk);
    {stall_id, stall_ex, if_valid, jump, branch, req, gnt, rvalid} = v;
    #1;
    tmo = m_active && (m_wait == TMO);
    if (!m_active)      e_busy = req;
    else if (tmo)       e_busy = 0;
    else if (!m_granted) e_busy = 1;
    else                e_busy = !rvalid;
    // k = number of leading registers held; register k gets a bubble
    hold = 1;
    if (e_busy)                  k = 4;
    else if (stall_ex)           k = 3;
    else if (stall_id)           k = 2;
    else if (branch || jump)     begin k = 0; hold = 0; end
    else if (!if_valid)          k = 1;
    else                         begin k = 0; hold = 0; end
    e_fl = '0;
    for (int i = 0; i < 5; i++) e_en[i] = (i >= k);
    if (hold) e_fl[k] = 1'b1;
    else if (branch) begin e_fl[1] = 1'b1; e_fl[2] = 1'b1; end
    else if (jump) e_fl[1] = 1'b1;
    redir = !hold && (branch || jump);
    check("ctrl", 64'(ctrl_vec()),
          64'({e_en[0], e_en[1], e_en[2], e_en[3], e_en[4],
               e_fl[1], e_fl[2], e_fl[3], e_fl[4], e_busy}));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    check("err", 64'(err), 64'(m_err));
    @(posedge clk);
    if (!e_en[0] && m_stall < MAX) m_stall++;
    if (redir && m_flush < MAX) m_flush++;
    if (!m_active) begin
      if (req) begin
        m_active  = 1;
        m_granted = gnt;
        m_wait    = 0;
      end
    end else if (tmo) begin
      m_active = 0;
      m_err    = 1;
    end else if (!m_granted) begin
      if (gnt) begin
        m_granted = 1;
        m_wait    = 0;
      end else m_wait++;
    end else if (rvalid) m_active = 0;
    else m_wait++;
  endtask

  task automatic check_cnt(input string tag, input int s, input int f);
    #1;
    check({tag, "_stall"}, 64'(stall_cnt), 64'(s));
    check({tag, "_flush"}, 64'(flush_cnt), 64'(f));
  endtask

  // Assert reset mid-cycle; outputs must follow with no clock edge
  task automatic async_reset();
    #3;
    {stall_id, stall_ex, if_valid, jump, branch} = 5'b00100;
    {req, gnt, rvalid} = 3'b100;
    rst = 1'b1;
    #1;
    check("rst_ctrl", 64'(ctrl_vec()), 64'(10'b0000011110));
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_flush", 64'(flush_cnt), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1;
    {stall_id, stall_ex, if_valid, jump, branch} = '0;
    {req, gnt, rvalid} = '0;
    model_clear();
    #2;
    check("init_ctrl", 64'(ctrl_vec()), 64'(10'b0000011110));
    check("init_stall", 64'(stall_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;

    repeat (10) step(8'h20);
    check_cnt("straight", 0, 0);

    step(8'hE0);
    check_cnt("load_use", 1, 0);

    step(8'h24);
    step(8'h24);
    step(8'h26);
    step(8'h20);
    step(8'h21);
    check_cnt("mem_wait", 5, 0);

    step(8'h2E);
    step(8'h28);
    step(8'h28);
    step(8'h29);
    check_cnt("br_wait", 8, 1);

    step(8'h26);
    repeat (5) step(8'h20);
    step(8'h20);
    check_cnt("timeout", 13, 1);
    check("timeout_err", 64'(err), 64'd1);

    step(8'h38);
    check_cnt("br_jump", 13, 2);

    step(8'h26);
    step(8'h20);
    async_reset();
    step(8'h20);
    check_cnt("post_rst", 0, 0);

    for (int n = 0; n < 3000; n++) begin
      v[7] = ($urandom % 5) == 0;
      v[6] = v[7] && ($urandom % 2);
      v[5] = ($urandom % 6) != 0;
      v[4] = ($urandom % 8) == 0;
      v[3] = ($urandom % 8) == 0;
      v[2] = ($urandom % 4) == 0;
      v[1] = $urandom % 2;
      v[0] = ($urandom % 3) == 0;
      step(v);
      if (($urandom % 300) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
